// File: rtl/fetch_queue_unit.sv
// Instruction fetch queue feeding the single-cycle LEGv8 core.
// Owns the fetch PC, keeps one word request outstanding to instruction
// memory, and buffers returned {pc, instr} pairs in a small FIFO.
// A redirect flushes the FIFO and discards any stale in-flight response.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   imem_req/imem_addr  : registered request to instruction memory
//   imem_ack/imem_rdata : request completion and returned instruction
//   inst_valid/ready    : valid/ready handshake to the core
//   inst_out/inst_pc    : FIFO head instruction and its PC
//   redirect_valid/pc   : branch redirect, low two PC bits forced to zero
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_out,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               drop_q, drop_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;

    logic [ADDR_W-1:0]  pc_mem_q  [DEPTH];
    logic [INSTR_W-1:0] ins_mem_q [DEPTH];

    logic [ADDR_W-1:0]  fetch_pc_nx;
    logic               acked;
    logic               push;
    logic               pop;
    logic               issue;

    // Next-state computation; redirect takes priority over push and pop.
    always_comb begin
        fetch_pc_nx = redirect_valid ? (redirect_pc & ~ADDR_W'(3)) : fetch_pc_q;
        acked       = req_q & imem_ack;
        push        = acked & ~drop_q & ~redirect_valid;
        pop         = valid_q & inst_ready & ~redirect_valid;

        count_d = redirect_valid ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
        head_d  = redirect_valid ? tail_q : (head_q + PTR_W'(pop));
        tail_d  = tail_q + PTR_W'(push);
        valid_d = (count_d != '0);

        // A stale response consumes the drop flag; a redirect over an
        // unanswered request arms it so that response is thrown away.
        drop_d = drop_q;
        if (acked && drop_q) begin
            drop_d = 1'b0;
        end
        if (redirect_valid && req_q && !imem_ack) begin
            drop_d = 1'b1;
        end

        // Only issue when the slot the response will need is guaranteed.
        issue      = (~req_q | acked) & (count_d < DEPTH_C);
        req_d      = req_q & ~acked;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_nx;
        if (issue) begin
            req_d      = 1'b1;
            addr_d     = fetch_pc_nx;
            fetch_pc_d = fetch_pc_nx + ADDR_W'(4);
        end
    end

    // Control and pointer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            drop_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
        end
    end

    // FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]  <= addr_q;
            ins_mem_q[tail_q] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= DEPTH_C);
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = valid_q;
    assign inst_out   = ins_mem_q[head_q];
    assign inst_pc    = pc_mem_q[head_q];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic,
// checked against a program-order scoreboard and a memory model.
module tb_fetch_queue_unit;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_out;
    logic [ADDR_W-1:0]  inst_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(64'd0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_pc   = 64'd0;
    int          pops     = 0;
    int          lat      = 0;
    int          wait_cnt = 0;
    bit          rand_mem = 1'b0;
    bit          force_ack = 1'b0;

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    // One clock: drive memory response, update scoreboard, advance, check protocol.
    task automatic tick();
        logic        p_req, p_ack, p_redir, p_reset;
        logic [63:0] p_addr;
        if (reset) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_req ? instr_of(imem_addr) : $urandom;
            wait_cnt   = 0;
        end else if (imem_req) begin
            if (rand_mem) imem_ack = ($urandom_range(0, 2) == 0);
            else          imem_ack = (wait_cnt >= lat);
            if (imem_ack) begin
                imem_rdata = instr_of(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end

        if (reset) begin
            exp_pc = 64'd0;
        end else begin
            if (inst_valid && inst_ready && !redirect_valid) begin
                n_checks++;
                if (inst_pc !== exp_pc || inst_out !== instr_of(exp_pc)) begin
                    n_fail++;
                    $display("FAIL pop_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             inst_pc, inst_out, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
        end

        p_req   = imem_req;
        p_ack   = imem_ack;
        p_addr  = imem_addr;
        p_redir = redirect_valid;
        p_reset = reset;
        @(posedge clk);
        @(negedge clk);

        if (!p_reset && p_req && !p_ack) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                n_fail++;
                $display("FAIL addr_hold: got req=%b addr=%h, expected req=1 addr=%h",
                         imem_req, imem_addr, p_addr);
            end
        end
        if (!p_reset && p_redir) begin
            n_checks++;
            if (inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_valid: got inst_valid=%b, expected 0", inst_valid);
            end
        end
        if (p_reset) begin
            n_checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got req=%b valid=%b, expected 0 0",
                         imem_req, inst_valid);
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        force_ack      = 1'b0;
        rand_mem       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_pops(input int need, input int bound, input string name);
        int start;
        start = pops;
        for (int i = 0; i < bound && (pops - start) < need; i++) tick();
        n_checks++;
        if ((pops - start) < need) begin
            n_fail++;
            $display("FAIL %s: got %0d pops, expected at least %0d", name, pops - start, need);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 64'd0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b addr=%h valid=%b, expected 0 0 0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat        = 0;
        inst_ready = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'(4 * (n - 1))) begin
                n_fail++;
                $display("FAIL stream_addr: got req=%b addr=%h, expected 1 %h",
                         imem_req, imem_addr, 64'(4 * (n - 1)));
            end
            n_checks++;
            if (n == 1) begin
                if (inst_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_first_valid: got %b, expected 0", inst_valid);
                end
            end else if (inst_valid !== 1'b1 || inst_pc !== 64'(4 * (n - 2))) begin
                n_fail++;
                $display("FAIL stream_head: got valid=%b pc=%h, expected 1 %h",
                         inst_valid, inst_pc, 64'(4 * (n - 2)));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        lat = 0;
        repeat (10) tick();
        n_checks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_pc !== 64'd0) begin
            n_fail++;
            $display("FAIL full_stall: got valid=%b req=%b pc=%h, expected 1 0 0",
                     inst_valid, imem_req, inst_pc);
        end
        inst_ready = 1'b1;
        wait_pops(5, 20, "full_drain");
    endtask

    task automatic test_redirect_drop();
        bit found;
        do_reset();
        lat        = 3;
        inst_ready = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (imem_req === 1'b1 && imem_addr === 64'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL drop_reach: got addr=%h, expected request to 8", imem_addr);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_hold: got req=%b addr=%h valid=%b, expected 1 8 0",
                     imem_req, imem_addr, inst_valid);
        end
        for (int i = 0; i < 20 && imem_addr === 64'h8; i++) tick();
        n_checks++;
        if (imem_addr !== 64'h100) begin
            n_fail++;
            $display("FAIL drop_next_addr: got %h, expected 100", imem_addr);
        end
        wait_pops(2, 40, "drop_refill");
    endtask

    task automatic test_redirect_on_ack();
        bit found;
        do_reset();
        lat        = 0;
        inst_ready = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req === 1'b1 && imem_addr === 64'h10) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL ack_redir_reach: got addr=%h, expected request to 10", imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h200 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_redir: got req=%b addr=%h valid=%b, expected 1 200 0",
                     imem_req, imem_addr, inst_valid);
        end
        wait_pops(2, 20, "ack_redir_refill");
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 3;
        repeat (10) tick();
        n_checks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b1 || inst_pc !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_setup: got valid=%b req=%b pc=%h, expected 1 1 0",
                     inst_valid, imem_req, inst_pc);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b req=%b, expected 0 0", inst_valid, imem_req);
        end
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL late_ack: got valid=%b req=%b addr=%h, expected 0 1 0",
                     inst_valid, imem_req, imem_addr);
        end
        lat        = 0;
        inst_ready = 1'b1;
        wait_pops(2, 20, "mid_restart");
    endtask

    task automatic test_wrap();
        do_reset();
        lat        = 0;
        inst_ready = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_top: got req=%b addr=%h, expected 1 fffffffffffffffc",
                     imem_req, imem_addr);
        end
        tick();
        n_checks++;
        if (imem_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got addr=%h, expected 0", imem_addr);
        end
        wait_pops(3, 20, "wrap_pops");
    endtask

    task automatic test_random();
        int start;
        do_reset();
        rand_mem = 1'b1;
        start    = pops;
        for (int i = 0; i < 3000; i++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) redirect_pc = {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom)};
            else                           redirect_pc = {$urandom, $urandom};
            tick();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (40) tick();
        rand_mem = 1'b0;
        n_checks++;
        if ((pops - start) < 50) begin
            n_fail++;
            $display("FAIL random_progress: got %0d pops, expected at least 50", pops - start);
        end
    endtask

    initial begin
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_on_ack();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
